pc_sequencer: RTL and testbench

//  Instruction-sequencing controller for the CPU program counter. Issues fetch

---
 rtl/pc_sequencer.sv | 143 ++++++++++++++
 tb/tb_pc_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Program-counter sequencing FSM: fetch, decode 2-bit opcode, drive
//            PC enable/load; paced by a free-run prescaler or single steps.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer #(
    parameter int WIDTH     = 6,
    parameter int WAIT_TIME = 135000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               step,
    input  logic               resume,
    input  logic               zero_flag,
    input  logic               instr_valid,
    input  logic [WIDTH+1:0]   instr,
    output logic               fetch_req,
    output logic               pc_enable,
    output logic               pc_load,
    output logic [WIDTH-1:0]   pc_target,
    output logic               exec_strobe,
    output logic               halted,
    output logic [1:0]         state
);

    localparam int CNT_W = $clog2(WAIT_TIME + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_JMP  = 2'b01;
    localparam logic [1:0] OP_JZ   = 2'b10;

    state_t             cur;
    state_t             nxt;
    logic [CNT_W-1:0]   presc;
    logic               tick_pend;
    logic               step_q;
    logic               resume_q;
    logic [WIDTH+1:0]   ir;

    logic               step_edge;
    logic               resume_edge;
    logic               go;
    logic               presc_run;
    logic               wrap;
    logic [1:0]         opcode;
    logic [WIDTH-1:0]   addr;

    assign step_edge   = step & ~step_q;
    assign resume_edge = resume & ~resume_q;
    assign go          = (cur == S_IDLE) & (tick_pend | step_edge);
    assign presc_run   = run & (cur != S_HALT);
    assign wrap        = presc_run & (presc == CNT_W'(WAIT_TIME - 1));
    assign opcode      = ir[WIDTH+1:WIDTH];
    assign addr        = ir[WIDTH-1:0];
    assign state       = cur;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur       <= S_IDLE;
            presc     <= '0;
            tick_pend <= 1'b0;
            step_q    <= 1'b0;
            resume_q  <= 1'b0;
            ir        <= '0;
        end else begin
            cur      <= nxt;
            step_q   <= step;
            resume_q <= resume;
            if (presc_run)
                presc <= wrap ? '0 : presc + CNT_W'(1);
            // HALT entry discards any pending tick; a fresh wrap beats consumption
            // so a tick landing on the go cycle is not lost.
            if (nxt == S_HALT && cur != S_HALT)
                tick_pend <= 1'b0;
            else if (wrap)
                tick_pend <= 1'b1;
            else if (go)
                tick_pend <= 1'b0;
            if (cur == S_FETCH && instr_valid)
                ir <= instr;
        end
    end

    always_comb begin
        nxt         = cur;
        fetch_req   = 1'b0;
        pc_enable   = 1'b0;
        pc_load     = 1'b0;
        pc_target   = '0;
        exec_strobe = 1'b0;
        halted      = 1'b0;
        case (cur)
            S_IDLE: begin
                if (go)
                    nxt = S_FETCH;
            end
            S_FETCH: begin
                fetch_req = 1'b1;
                if (instr_valid)
                    nxt = S_EXEC;
            end
            S_EXEC: begin
                exec_strobe = 1'b1;
                nxt         = S_IDLE;
                case (opcode)
                    OP_NOP: pc_enable = 1'b1;
                    OP_JMP: begin
                        pc_load   = 1'b1;
                        pc_target = addr;
                    end
                    OP_JZ: begin
                        if (zero_flag) begin
                            pc_load   = 1'b1;
                            pc_target = addr;
                        end else begin
                            pc_enable = 1'b1;
                        end
                    end
                    default: nxt = S_HALT;
                endcase
            end
            default: begin
                halted = 1'b1;
                if (resume_edge)
                    nxt = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Directed self-checking bench for pc_sequencer (WIDTH=6, WAIT_TIME=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic       step;
    logic       resume;
    logic       zero_flag;
    logic       instr_valid;
    logic [7:0] instr;
    logic       fetch_req;
    logic       pc_enable;
    logic       pc_load;
    logic [5:0] pc_target;
    logic       exec_strobe;
    logic       halted;
    logic [1:0] state;

    int         n_vec  = 0;
    int         n_fail = 0;

    logic [7:0] mem_word;
    int         mem_delay;
    int         wait_cnt;

    pc_sequencer #(.WIDTH(6), .WAIT_TIME(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .step        (step),
        .resume      (resume),
        .zero_flag   (zero_flag),
        .instr_valid (instr_valid),
        .instr       (instr),
        .fetch_req   (fetch_req),
        .pc_enable   (pc_enable),
        .pc_load     (pc_load),
        .pc_target   (pc_target),
        .exec_strobe (exec_strobe),
        .halted      (halted),
        .state       (state)
    );

    always #5 clk = ~clk;

    // Instruction memory: valid after mem_delay cycles of fetch_req
    assign instr       = mem_word;
    assign instr_valid = fetch_req && (wait_cnt >= mem_delay);

    always @(posedge clk or posedge reset) begin
        if (reset)
            wait_cnt <= 0;
        else if (fetch_req && !instr_valid)
            wait_cnt <= wait_cnt + 1;
        else
            wait_cnt <= 0;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) cyc();
        n_vec++;
        if ({fetch_req, pc_enable, pc_load, pc_target, exec_strobe, halted, state} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {fetch_req, pc_enable, pc_load, pc_target, exec_strobe, halted, state});
        end
        reset = 1'b0;
        mem_delay = 100;
        step = 1'b1;
        cyc();
        step = 1'b0;
        n_vec++;
        if (fetch_req !== 1'b1) begin
            n_fail++;
            $display("FAIL step_fetch: fetch_req=%b expected 1", fetch_req);
        end
        cyc();
        #2 reset = 1'b1;
        #1;
        n_vec++;
        if (fetch_req !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_fetch: fetch_req=%b expected 0", fetch_req);
        end
        n_vec++;
        if (state !== 2'd0) begin
            n_fail++;
            $display("FAIL async_reset_state: state=%0d expected 0", state);
        end
        cyc();
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            n_vec++;
            if (fetch_req !== 1'b0) begin
                n_fail++;
                $display("FAIL no_fetch_after_reset cyc %0d: fetch_req=%b expected 0", k, fetch_req);
            end
        end
    endtask

    task automatic test_run_nop();
        logic exp_en;
        mem_word  = 8'h00;
        mem_delay = 0;
        run       = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            exp_en = (k >= 6) && ((k - 6) % 4 == 0);
            n_vec++;
            if (pc_enable !== exp_en || exec_strobe !== exp_en || pc_load !== 1'b0) begin
                n_fail++;
                $display("FAIL run_nop k=%0d: en=%b strobe=%b load=%b expected en=strobe=%b load=0",
                         k, pc_enable, exec_strobe, pc_load, exp_en);
            end
        end
        run = 1'b0;
        repeat (4) cyc();
    endtask

    task automatic test_step_jmp();
        mem_word  = 8'h6A;
        mem_delay = 3;
        step      = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            step = 1'b0;
            n_vec++;
            if (fetch_req !== 1'b1) begin
                n_fail++;
                $display("FAIL jmp_fetch k=%0d: fetch_req=%b expected 1", k, fetch_req);
            end
        end
        cyc();
        n_vec++;
        if ({fetch_req, pc_enable, pc_load, pc_target, exec_strobe} !== {1'b0, 1'b0, 1'b1, 6'h2A, 1'b1}) begin
            n_fail++;
            $display("FAIL jmp_exec: fr=%b en=%b ld=%b tgt=%h stb=%b expected fr=0 en=0 ld=1 tgt=2a stb=1",
                     fetch_req, pc_enable, pc_load, pc_target, exec_strobe);
        end
        cyc();
        n_vec++;
        if ({pc_load, pc_target, state} !== 9'h000) begin
            n_fail++;
            $display("FAIL jmp_after: ld=%b tgt=%h state=%0d expected 0/00/0", pc_load, pc_target, state);
        end
    endtask

    task automatic test_jz();
        mem_word  = 8'h90;
        mem_delay = 0;
        zero_flag = 1'b1;
        step = 1'b1;
        cyc();
        step = 1'b0;
        cyc();
        n_vec++;
        if ({pc_enable, pc_load, pc_target} !== {1'b0, 1'b1, 6'h10}) begin
            n_fail++;
            $display("FAIL jz_taken: en=%b ld=%b tgt=%h expected en=0 ld=1 tgt=10", pc_enable, pc_load, pc_target);
        end
        cyc();
        zero_flag = 1'b0;
        step = 1'b1;
        cyc();
        step = 1'b0;
        cyc();
        n_vec++;
        if ({pc_enable, pc_load, pc_target, exec_strobe} !== {1'b1, 1'b0, 6'h00, 1'b1}) begin
            n_fail++;
            $display("FAIL jz_not_taken: en=%b ld=%b tgt=%h stb=%b expected en=1 ld=0 tgt=00 stb=1",
                     pc_enable, pc_load, pc_target, exec_strobe);
        end
        cyc();
    endtask

    task automatic test_halt();
        bit found;
        mem_word  = 8'hC0;
        mem_delay = 0;
        run       = 1'b1;
        found     = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            cyc();
            if (exec_strobe === 1'b1) found = 1'b1;
        end
        n_vec++;
        if (!found || pc_enable !== 1'b0 || pc_load !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_exec: seen=%b en=%b ld=%b expected seen=1 en=0 ld=0", found, pc_enable, pc_load);
        end
        for (int k = 0; k < 10; k++) begin
            cyc();
            step = (k == 3);
            n_vec++;
            if ({fetch_req, halted, state} !== {1'b0, 1'b1, 2'd3}) begin
                n_fail++;
                $display("FAIL halt_hold k=%0d: fr=%b halted=%b state=%0d expected 0/1/3",
                         k, fetch_req, halted, state);
            end
        end
        step     = 1'b0;
        mem_word = 8'h00;
        resume   = 1'b1;
        cyc();
        resume = 1'b0;
        n_vec++;
        if ({fetch_req, halted, state} !== 4'b0000) begin
            n_fail++;
            $display("FAIL resume_idle: fr=%b halted=%b state=%0d expected 0/0/0", fetch_req, halted, state);
        end
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            cyc();
            if (fetch_req === 1'b1) found = 1'b1;
        end
        run = 1'b0;
        n_vec++;
        if (!found) begin
            n_fail++;
            $display("FAIL resume_fetch: fetch_req seen=%b expected 1 within 8 cycles", found);
        end
        repeat (4) cyc();
    endtask

    task automatic test_back_to_back();
        int strobes;
        reset = 1'b1;
        cyc();
        reset     = 1'b0;
        mem_word  = 8'h00;
        mem_delay = 3;
        cyc();
        step = 1'b1;
        cyc();
        step = 1'b0;
        cyc();
        step = 1'b1;
        cyc();
        step = 1'b0;
        strobes = (exec_strobe === 1'b1) ? 1 : 0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (exec_strobe === 1'b1) strobes++;
        end
        n_vec++;
        if (strobes != 1) begin
            n_fail++;
            $display("FAIL step_in_fetch: exec_strobe count=%0d expected 1", strobes);
        end
        mem_delay = 0;
        run = 1'b1;
        repeat (4) cyc();
        step = 1'b1;
        run  = 1'b0;
        strobes = 0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            step = 1'b0;
            if (exec_strobe === 1'b1) strobes++;
        end
        n_vec++;
        if (strobes != 1) begin
            n_fail++;
            $display("FAIL tick_plus_step: exec_strobe count=%0d expected 1", strobes);
        end
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; step = 1'b0; resume = 1'b0; zero_flag = 1'b0;
        mem_word = 8'h00; mem_delay = 0;
        test_reset();
        test_run_nop();
        test_step_jmp();
        test_jz();
        test_halt();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
